// File: rtl/mem_pkg.sv
// Shared definitions for the memory readout path: default geometry and
// the readout FSM state encoding.
package mem_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 5;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t FETCH   = 2'd1;
    localparam state_t PRESENT = 2'd2;
    localparam state_t DONE    = 2'd3;

endpackage

// File: rtl/mem_reader.sv
// Walks a small combinational-read memory from address 0 to a latched last
// address, presenting each word plus its sum with the following word.
module mem_reader
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_manual,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] last_adr,
    input  logic              loop,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_adr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] rd_data_next,
    output logic [DATA_W-1:0] out_value,
    output logic [DATA_W:0]   out_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   idx, idx_nxt;
    logic [ADDR_W-1:0]   last_q, last_nxt;
    logic                loop_q, loop_nxt;
    logic [DATA_W-1:0]   value_q, value_nxt;
    logic [DATA_W:0]     sum_q, sum_nxt;
    logic                valid_q, valid_nxt;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        last_nxt  = last_q;
        loop_nxt  = loop_q;
        value_nxt = value_q;
        sum_nxt   = sum_q;
        valid_nxt = valid_q;

        case (state)
            IDLE: begin
                idx_nxt = '0;
                if (start) begin
                    state_nxt = FETCH;
                    last_nxt  = last_adr;
                    loop_nxt  = loop;
                end
            end
            FETCH: begin
                value_nxt = rd_data;
                sum_nxt   = {1'b0, rd_data} + {1'b0, rd_data_next};
                valid_nxt = 1'b1;
                state_nxt = PRESENT;
            end
            PRESENT: begin
                if (out_ready) begin
                    valid_nxt = 1'b0;
                    if (idx != last_q) begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = FETCH;
                    end else if (loop_q) begin
                        idx_nxt   = '0;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                idx_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                idx_nxt   = '0;
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase

        // Abort overrides everything, including a pending handshake or start.
        if (abort) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_manual or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx     <= '0;
            last_q  <= '0;
            loop_q  <= 1'b0;
            value_q <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            last_q  <= last_nxt;
            loop_q  <= loop_nxt;
            value_q <= value_nxt;
            sum_q   <= sum_nxt;
            valid_q <= valid_nxt;
        end
    end

    assign rd_adr    = idx;
    assign out_value = value_q;
    assign out_sum   = sum_q;
    assign out_valid = valid_q;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE) && !abort;

endmodule

// File: doc/mem_reader.md
MEM_READER -- requirements
Module: mem_reader

Interface
REQ-001 Parameter ADDR_W, default 3, address width of the 8-entry value memory.
REQ-002 Parameter DATA_W, default 5, width of each stored value.
REQ-003 clk_manual  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request to begin a readout; sampled only in IDLE.
REQ-006 last_adr  input  ADDR_W  highest address to read (inclusive); latched on accepted start.
REQ-007 loop  input  1  1 = wrap to address 0 after last_adr and continue; latched on accepted start.
REQ-008 abort  input  1  terminate readout.
REQ-009 rd_adr  output  ADDR_W  address driven to the memory's combinational read port.
REQ-010 rd_data  input  DATA_W  memory word at rd_adr, same-cycle (combinational) read.
REQ-011 rd_data_next  input  DATA_W  memory word at rd_adr+1 mod 2**ADDR_W, same-cycle read.
REQ-012 out_value  output  DATA_W  registered value read from memory.
REQ-013 out_sum  output  DATA_W+1  registered rd_data + rd_data_next captured with out_value.
REQ-014 out_valid  output  1  out_value/out_sum are valid.
REQ-015 out_ready  input  1  consumer accepts the output word.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 done  output  1  one-cycle pulse when a non-looping readout completes.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, PRESENT, DONE.
REQ-019 IDLE: start=1 -> FETCH; idx <= 0; last_adr and loop latched; otherwise stay.
REQ-020 FETCH: rd_adr = idx; next edge captures out_value <= rd_data and out_sum <= rd_data + rd_data_next (zero-extended, no overflow); -> PRESENT.
REQ-021 PRESENT: out_valid=1; out_value, out_sum and rd_adr held stable until out_ready=1.
REQ-022 PRESENT with out_ready=1 and idx != last_adr: idx <= idx+1; -> FETCH.
REQ-023 PRESENT with out_ready=1, idx == last_adr, loop=1: idx <= 0; -> FETCH.
REQ-024 PRESENT with out_ready=1, idx == last_adr, loop=0: -> DONE.
REQ-025 DONE: done=1 for exactly one cycle; -> IDLE.
REQ-026 Latency: start accepted at edge N -> out_valid high after edge N+2; each subsequent word 2 cycles after the previous handshake.
REQ-027 idx arithmetic SHALL wrap modulo 2**ADDR_W; at idx=7, out_sum uses mem[0] as the next word.
REQ-028 last_adr=0 SHALL produce exactly one word (address 0).
REQ-029 abort=1 in any state SHALL force IDLE at the next edge, clear out_valid, suppress done; abort takes priority over start and out_ready.
REQ-030 start while busy SHALL be ignored; changes to last_adr/loop while busy SHALL have no effect.
REQ-031 out_valid SHALL never drop without a handshake except on abort or reset.
REQ-032 rd_adr SHALL equal idx in every state; in IDLE, idx holds 0.

Reset
REQ-033 reset_n=0 SHALL immediately force IDLE, idx=0, rd_adr=0, out_value=0, out_sum=0, out_valid=0, busy=0, done=0, latched last_adr=0, loop=0.
REQ-034 Reset mid-readout SHALL discard the readout; no done pulse follows release.
REQ-035 After reset release, the first start is accepted on the first rising edge.

Structure
REQ-036 ADDR_W, DATA_W defaults and the state enum SHALL live in shared package mem_pkg, reused by the memory block.
REQ-037 Single module; no sub-module required; one always_ff for state/registers, one always_comb for next-state.

Verification
REQ-038 mem = {3,7,1,31,0,12,5,9} (addr 0..7), last_adr=3, loop=0, out_ready=1 -> words (3,10),(7,8),(1,32),(31,31), then done pulse, busy=0.
REQ-039 Same memory, last_adr=7, loop=1 -> word at addr 7 is (9,12) using mem[0], then addr 0 (3,10) repeats; abort -> out_valid=0, done never pulses.
REQ-040 out_ready held 0 for 5 cycles in PRESENT -> out_value, out_sum, rd_adr stable for all 5 cycles; one word delivered on release.
REQ-041 last_adr=0 -> exactly one word (3,10), done 2 cycles after start-accept plus handshake.
REQ-042 start pulsed during busy -> sequence unchanged; reset_n=0 at word 2 -> all outputs 0 immediately, IDLE, no done.
REQ-043 start and abort asserted together in IDLE -> remains IDLE, busy=0.
